memory_writer: RTL and testbench
================================

MEMORY_WRITER -- requirements
Module: memory_writer

Interface
REQ-001 SHALL have parameter WIDTH, default 5, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, number of words per load pass; legal range 2..256.
REQ-003 SHALL derive local AW = max(1, clog2(DEPTH)), the address width.
REQ-004 SHALL have port CLK  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port ASYNCRESETN  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port START  input  1  begin a load pass; sampled only in IDLE.
REQ-007 SHALL have port IN_VALID  input  1  IN_DATA holds a word.
REQ-008 SHALL have port IN_DATA  input  WIDTH  word to be written.
REQ-009 SHALL have port IN_READY  output  1  writer accepts a word this cycle.
REQ-010 SHALL have port WEN  output  1  memory write enable, registered.
REQ-011 SHALL have port WADDR  output  AW  memory write address, registered.
REQ-012 SHALL have port WDATA  output  WIDTH  memory write data, registered.
REQ-013 SHALL have port BUSY  output  1  high in WRITE state.
REQ-014 SHALL have port DONE  output  1  one-cycle pulse on pass completion.
REQ-015 SHALL have port COUNT  output  AW+1  words accepted in current or last pass.

Function
REQ-016 SHALL implement FSM states IDLE, WRITE, FINISH; reset state IDLE.
REQ-017 IDLE: IN_READY=0, BUSY=0; START=1 -> WRITE next cycle, internal address and COUNT cleared to 0.
REQ-018 WRITE: IN_READY=1 (combinational from state only, never from IN_VALID), BUSY=1.
REQ-019 Transfer occurs in a cycle where IN_VALID=1 and IN_READY=1; no transfer otherwise, with address, COUNT and state held.
REQ-020 On transfer, next cycle SHALL show WEN=1, WADDR=current address, WDATA=IN_DATA (latency exactly 1 cycle).
REQ-021 In any cycle without a transfer in the previous cycle, WEN SHALL be 0; WADDR and WDATA SHALL hold last values.
REQ-022 On transfer, address increments by 1 and COUNT increments by 1.
REQ-023 Transfer at address DEPTH-1 SHALL move state to FINISH; address wraps to 0; no further word accepted in that pass.
REQ-024 FINISH: IN_READY=0, BUSY=0, DONE=1 for exactly that cycle, coinciding with WEN=1 for address DEPTH-1; next state IDLE.
REQ-025 START asserted in WRITE or FINISH SHALL be ignored.
REQ-026 START asserted in IDLE the cycle after FINISH SHALL begin a new pass normally.
REQ-027 COUNT SHALL equal DEPTH after a full pass and hold until the next accepted START.
REQ-028 Writes SHALL be strictly sequential from address 0; no address skipped or repeated within a pass.

Reset
REQ-029 ASYNCRESETN=0 SHALL immediately, without a clock edge, force state IDLE, WEN=0, WADDR=0, WDATA=0, IN_READY=0, BUSY=0, DONE=0, COUNT=0.
REQ-030 Reset asserted mid-pass SHALL abandon the pass; no write SHALL occur after reset assertion, including one pending from a transfer in the preceding cycle.
REQ-031 After ASYNCRESETN deassertion, the block SHALL remain in IDLE until START is sampled high.

Verification
REQ-032 Full pass, DEPTH=4, WIDTH=5, IN_VALID held high, words 5,0,21,11 -> WEN high 4 consecutive cycles; (WADDR,WDATA) = (0,5),(1,0),(2,21),(3,11); DONE with last write; COUNT=4.
REQ-033 Backpressure gaps: IN_VALID pattern 1,0,0,1,1,0,1 -> exactly 4 writes, addresses 0..3 in order, WEN low in each gap cycle, DONE on the 4th write.
REQ-034 START pulsed during WRITE after 2 transfers -> ignored; pass completes with COUNT=4 and addresses 0..3.
REQ-035 ASYNCRESETN low between clock edges after 2 transfers -> outputs zero at once with no clock edge; new START then writes from address 0.
REQ-036 START held high continuously -> back-to-back passes each 4 writes plus 1 IDLE cycle; DONE pulses once per pass.
REQ-037 IN_VALID high in IDLE with START low -> IN_READY=0, WEN never asserts, COUNT unchanged.

Source files
------------

// File: rtl/memory_writer.sv
// Sequential memory loader: on START, accepts DEPTH words over a valid/ready
// handshake and writes them to consecutive addresses with one cycle of latency.
module memory_writer #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 4,
  localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1
) (
  input  logic             CLK,
  input  logic             ASYNCRESETN,
  input  logic             START,
  input  logic             IN_VALID,
  input  logic [WIDTH-1:0] IN_DATA,
  output logic             IN_READY,
  output logic             WEN,
  output logic [AW-1:0]    WADDR,
  output logic [WIDTH-1:0] WDATA,
  output logic             BUSY,
  output logic             DONE,
  output logic [AW:0]      COUNT
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    FINISH = 2'd2
  } state_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  state_t           state_q, state_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [AW:0]      count_q, count_d;
  logic             wen_q, wen_d;
  logic [AW-1:0]    waddr_q, waddr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Ready depends on state alone so it never forms a loop with IN_VALID.
  assign IN_READY = (state_q == WRITE);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    wen_d   = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (START) begin
          state_d = WRITE;
          addr_d  = '0;
          count_d = '0;
        end
      end
      WRITE: begin
        if (IN_VALID) begin
          wen_d   = 1'b1;
          waddr_d = addr_q;
          wdata_d = IN_DATA;
          count_d = count_q + (AW+1)'(1);
          if (addr_q == LAST_ADDR) begin
            state_d = FINISH;
            addr_d  = '0;
            done_d  = 1'b1;
          end else begin
            addr_d = addr_q + AW'(1);
          end
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == WRITE);
  end

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      state_q <= IDLE;
      addr_q  <= '0;
      count_q <= '0;
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign WEN   = wen_q;
  assign WADDR = waddr_q;
  assign WDATA = wdata_q;
  assign BUSY  = busy_q;
  assign DONE  = done_q;
  assign COUNT = count_q;

endmodule

// File: tb/tb_memory_writer.sv
// Directed and randomized checks of memory_writer against a pass-level
// reference model that tracks words accepted and the write they produce.
module tb_memory_writer;

  localparam int WIDTH = 5;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic             CLK = 1'b0;
  logic             ASYNCRESETN;
  logic             START;
  logic             IN_VALID;
  logic [WIDTH-1:0] IN_DATA;
  logic             IN_READY;
  logic             WEN;
  logic [AW-1:0]    WADDR;
  logic [WIDTH-1:0] WDATA;
  logic             BUSY;
  logic             DONE;
  logic [AW:0]      COUNT;

  memory_writer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .ASYNCRESETN(ASYNCRESETN), .START(START), .IN_VALID(IN_VALID),
    .IN_DATA(IN_DATA), .IN_READY(IN_READY), .WEN(WEN), .WADDR(WADDR),
    .WDATA(WDATA), .BUSY(BUSY), .DONE(DONE), .COUNT(COUNT)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int passes = 0;

  // Reference model: a pass is either collecting words, finishing, or absent.
  bit               m_active, m_fin, m_wen;
  int               m_acc, m_count, m_waddr;
  logic [WIDTH-1:0] m_wdata;
  int               done_seen;

  task automatic model_reset();
    m_active = 0; m_fin = 0; m_wen = 0;
    m_acc = 0; m_count = 0; m_waddr = 0; m_wdata = '0;
  endtask

  task automatic model_edge(input logic s, input logic v, input logic [WIDTH-1:0] d);
    bit trans;
    trans = m_active && v;
    m_wen = trans;
    if (trans) begin
      m_waddr = m_acc;
      m_wdata = d;
      m_acc++;
      m_count = m_acc;
    end
    if (m_fin) m_fin = 0;
    else if (m_active) begin
      if (trans && m_acc == DEPTH) begin
        m_active = 0;
        m_fin = 1;
      end
    end else if (s) begin
      m_active = 1;
      m_acc = 0;
      m_count = 0;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic compare_all(input string tag);
    logic [AW-1:0] ea;
    ea = AW'(m_waddr);
    check({tag, ":ready_busy_done"}, {29'd0, IN_READY, BUSY, DONE},
          {29'd0, m_active, m_active, m_fin});
    check({tag, ":wen"}, {31'd0, WEN}, {31'd0, m_wen});
    check({tag, ":waddr_wdata"}, {25'd0, WADDR, WDATA}, {25'd0, ea, m_wdata});
    check({tag, ":count"}, {29'd0, COUNT}, 32'(m_count));
    if (DONE === 1'b1) done_seen++;
  endtask

  task automatic step(input logic s, input logic v, input logic [WIDTH-1:0] d, input string tag);
    START = s; IN_VALID = v; IN_DATA = d;
    #1;
    compare_all(tag);
    @(posedge CLK);
    model_edge(s, v, d);
    #1;
  endtask

  // Reset dropped mid-cycle, right after a transfer whose write is showing.
  task automatic async_reset(input string tag);
    #2;
    ASYNCRESETN = 1'b0; START = 1'b0; IN_VALID = 1'b0;
    #1;
    model_reset();
    compare_all({tag, "_immediate"});
    @(posedge CLK); #1;
    compare_all({tag, "_held"});
    #2;
    ASYNCRESETN = 1'b1;
    @(posedge CLK);
    model_edge(1'b0, 1'b0, '0);
    #1;
  endtask

  initial begin
    ASYNCRESETN = 1'b0; START = 1'b0; IN_VALID = 1'b0; IN_DATA = '0;
    model_reset();
    done_seen = 0;
    #1;
    compare_all("reset");
    #11;
    ASYNCRESETN = 1'b1;
    @(posedge CLK); #1;
    model_edge(1'b0, 1'b0, '0);

    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 5'd9, "idle_valid");

    step(1'b1, 1'b0, 5'd0, "full_start");
    step(1'b0, 1'b1, 5'd5, "full_w0");
    step(1'b0, 1'b1, 5'd0, "full_w1");
    step(1'b0, 1'b1, 5'd21, "full_w2");
    step(1'b0, 1'b1, 5'd11, "full_w3");
    step(1'b0, 1'b1, 5'd30, "full_finish");
    step(1'b0, 1'b1, 5'd30, "full_after");
    check("full_done_pulses", 32'(done_seen), 32'd1);

    step(1'b1, 1'b0, 5'd0, "bp_start");
    begin
      logic [6:0] pat;
      pat = 7'b1011001;
      for (int i = 0; i < 7; i++) step(1'b0, pat[i], 5'(i + 3), "bp_gap");
    end
    step(1'b0, 1'b0, 5'd0, "bp_finish");
    step(1'b0, 1'b0, 5'd0, "bp_idle");

    step(1'b1, 1'b0, 5'd0, "ign_start");
    step(1'b0, 1'b1, 5'd1, "ign_w0");
    step(1'b0, 1'b1, 5'd2, "ign_w1");
    step(1'b1, 1'b0, 5'd0, "ign_start_in_write");
    step(1'b1, 1'b1, 5'd3, "ign_w2");
    step(1'b0, 1'b1, 5'd4, "ign_w3");
    step(1'b1, 1'b1, 5'd7, "ign_start_in_finish");
    step(1'b1, 1'b0, 5'd0, "restart_after_finish");
    step(1'b0, 1'b1, 5'd17, "restart_w0");

    step(1'b0, 1'b1, 5'd18, "rst_w1");
    async_reset("rst_mid_pass");
    step(1'b0, 1'b1, 5'd6, "rst_stays_idle");
    step(1'b1, 1'b0, 5'd0, "rst_new_start");
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 5'(20 + i), "rst_new_pass");

    done_seen = 0;
    for (int i = 0; i < 18; i++) step(1'b1, 1'b1, 5'(i), "start_held");
    check("start_held_done_pulses", 32'(done_seen), 32'd3);
    step(1'b0, 1'b0, 5'd0, "start_held_drain");
    step(1'b0, 1'b0, 5'd0, "start_held_drain");

    for (int i = 0; i < 300; i++)
      step(($urandom_range(0, 3) == 0), ($urandom_range(0, 2) != 0),
           5'($urandom_range(0, 31)), "random");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
